game_timer: RTL
===============

# game_timer

Parametrised game-clock block for the maze game: divides the system clock into a configurable tick rate and counts seconds up or down between 0 and a loaded limit. It supports start, pause and clear controls, and flags expiry with a one-cycle pulse plus a held level. It sits between game-state control, which drives start, pause and clear and consumes expiry, and the HUD renderer, which displays `time_out`. It replaces the fixed-function second counter with a width-, rate- and direction-configurable version.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000: input clock frequency.
- `TICK_HZ`, default 1: count rate. `DIV = CLK_FREQ_HZ / TICK_HZ`; must divide exactly, and `DIV >= 2`.
- `WIDTH`, default 10: width of the limit and count.
- `clk_100mhz_in`, in, 1: the only clock; all logic is rising-edge.
- `rst_in`, in, 1: asynchronous, active-low reset.
- `start_in`, in, 1: single-cycle pulse. Samples `max_in` and `mode_in`, loads the count, enters RUN.
- `pause_in`, in, 1: level. While high in RUN or PAUSED, counting halts.
- `clear_in`, in, 1: single-cycle pulse. Returns to IDLE with count 0.
- `mode_in`, in, 1: 0 = count up from 0 to the limit; 1 = count down from the limit to 0.
- `max_in`, in, `WIDTH`: limit value.
- `time_out`, out, `WIDTH`: current count (registered).
- `tick_out`, out, 1: one-cycle pulse on every cycle in which `time_out` changes because of a tick.
- `running_out`, out, 1: high in RUN.
- `done_out`, out, 1: high in DONE.
- `expired_out`, out, 1: one-cycle pulse on entry to DONE.

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Reset state: IDLE. All outputs 0, prescaler 0, latched limit and mode 0.
- Control priority per cycle: `clear_in`, then `start_in`, then `pause_in`.
- `clear_in` from any state:
  - go to IDLE;
  - `time_out` = 0, prescaler = 0;
  - no `expired_out`.
- `start_in` from any state (restarts an active or finished run):
  - latch `max_in` into `lim` and `mode_in` into `md`;
  - prescaler = 0;
  - `time_out` = 0 if `md` = 0, else `max_in`.
- Start with `max_in` = 0: go straight to DONE with `time_out` = 0 and pulse `expired_out`. Otherwise go to RUN.
- `max_in` and `mode_in` are ignored at all times other than a start.
- RUN with `pause_in` high: go to PAUSED. Prescaler and count freeze.
- PAUSED with `pause_in` low: go to RUN. The prescaler resumes from its frozen value, so a partial second is preserved.
- Prescaler in RUN with `pause_in` low: counts 0..DIV-1 and wraps to 0. The tick occurs in the cycle where the prescaler equals DIV-1.
- On a tick:
  - up mode: `time_out` + 1;
  - down mode: `time_out` - 1;
  - assert `tick_out` in the same cycle the new value becomes visible.
- Final tick (up mode: `time_out` = `lim`-1; down mode: `time_out` = 1):
  - `time_out` takes its final value (`lim` or 0);
  - state goes to DONE on the same edge;
  - `expired_out` and `tick_out` pulse together for that one cycle.
- DONE holds `time_out`. `done_out` stays high until start, clear or reset.
- Arithmetic: the count never wraps. It stays within 0..`lim`. `lim` at all-ones (1023 for `WIDTH` = 10) is legal.
- Prescaler width: `$clog2(DIV)`.

## Timing
- All outputs are registered.
- Start sampled on edge E:
  - `time_out` loaded and `running_out` high after E;
  - first tick is visible after edge E+DIV, assuming no pause.
- Pause sampled on edge P: no tick is produced on edge P or later. A tick whose prescaler reaches DIV-1 in the same cycle that `pause_in` is high is suppressed.
- Resume: `pause_in` is low at edge R, state = RUN after R. A frozen prescaler value `k` produces the next tick (DIV-1-`k`) cycles later.
- Clear and start take effect on the sampling edge and have no dead cycles.
- Start and clear in the same cycle: clear wins.
- Asynchronous reset assertion mid-run forces all outputs to 0 immediately. Deassertion is synchronised by the reset-release convention; the first active edge finds IDLE.

## Test plan
Parameters for all scenarios: `CLK_FREQ_HZ` = 10, `TICK_HZ` = 1, so DIV = 10.
- **Up count:** `mode_in`=0, `max_in`=3, start pulse.
  - `time_out` steps to 1, 2, 3 at 10, 20, 30 cycles after start, each with `tick_out`.
  - `expired_out` pulses once at cycle 30; `done_out` is held afterwards.
- **Down count:** `mode_in`=1, `max_in`=2.
  - `time_out` = 2 right after start, then 1 at cycle 10 and 0 at cycle 20 with `expired_out`.
  - `max_in` changed to 7 mid-run has no effect.
- **Pause:** up, `max_in`=5, `pause_in` high from cycle 14 to 30.
  - `time_out` = 1 throughout the pause.
  - Next tick at cycle 36, because the prescaler resumes from 4.
- **Zero limit and restart:** start with `max_in`=0 goes to DONE with `expired_out` one cycle after start and `time_out`=0. A new start with `max_in`=1 produces `time_out`=1 at cycle 10.
- **Clear priority:**
  - `clear_in` and `start_in` together during RUN: IDLE, `time_out`=0, no `expired_out`.
  - `clear_in` in DONE drops `done_out`.
- **Async reset:** `rst_in` low mid-run, between clock edges, zeroes all outputs immediately. After release, the block stays idle until a start.

Source files
------------

// File: rtl/game_timer.sv
// Game clock: divides clk_100mhz_in down to TICK_HZ and counts seconds up or
// down between 0 and a limit latched at start, with pause, clear and expiry.
module game_timer #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 1,
    parameter int WIDTH       = 10
) (
    input  logic             clk_100mhz_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             pause_in,
    input  logic             clear_in,
    input  logic             mode_in,
    input  logic [WIDTH-1:0] max_in,
    output logic [WIDTH-1:0] time_out,
    output logic             tick_out,
    output logic             running_out,
    output logic             done_out,
    output logic             expired_out
);

    // state    | meaning
    // S_IDLE   | cleared or after reset, count 0, waiting for start
    // S_RUN    | prescaler advancing, count moves on each tick
    // S_PAUSED | prescaler and count frozen while pause_in is high
    // S_DONE   | final value reached, count held until start/clear

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PS_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] time_q, time_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             md_q, md_d;
    logic             tick_q, tick_d;
    logic             exp_q, exp_d;

    // Assertion clears everything at once; release is retimed to the clock.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_100mhz_in or negedge rst_in) begin
        if (!rst_in) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    always_ff @(posedge clk_100mhz_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            time_q  <= '0;
            lim_q   <= '0;
            md_q    <= 1'b0;
            tick_q  <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            time_q  <= time_d;
            lim_q   <= lim_d;
            md_q    <= md_d;
            tick_q  <= tick_d;
            exp_q   <= exp_d;
        end
    end

    logic step;
    logic last_tick;

    // Resuming from PAUSED advances the prescaler on the resume edge itself.
    assign step = ((state_q == S_RUN) || (state_q == S_PAUSED)) && !pause_in;
    assign last_tick = md_q ? (time_q == ONE) : (time_q == WIDTH'(lim_q - ONE));

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        time_d  = time_q;
        lim_d   = lim_q;
        md_d    = md_q;
        tick_d  = 1'b0;
        exp_d   = 1'b0;

        if (clear_in) begin
            state_d = S_IDLE;
            presc_d = '0;
            time_d  = '0;
        end else if (start_in) begin
            lim_d   = max_in;
            md_d    = mode_in;
            presc_d = '0;
            time_d  = mode_in ? max_in : '0;
            if (max_in == '0) begin
                state_d = S_DONE;
                exp_d   = 1'b1;
            end else begin
                state_d = S_RUN;
            end
        end else if ((state_q == S_RUN) && pause_in) begin
            state_d = S_PAUSED;
        end else if (step) begin
            state_d = S_RUN;
            if (presc_q == PS_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
                time_d  = md_q ? WIDTH'(time_q - ONE) : WIDTH'(time_q + ONE);
                if (last_tick) begin
                    state_d = S_DONE;
                    exp_d   = 1'b1;
                end
            end else begin
                presc_d = PW'(presc_q + PW'(1));
            end
        end
    end

    assign time_out    = time_q;
    assign tick_out    = tick_q;
    assign expired_out = exp_q;
    assign running_out = (state_q == S_RUN);
    assign done_out    = (state_q == S_DONE);

endmodule
